// File: rtl/tensor_ram_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tensor_ram_streamer
//  Description : Issues consecutive tensor RAM word reads, buffers the four
//                32-bit lanes and streams them out over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tensor_ram_streamer #(
    parameter  int DEPTH_WORDS = 1024,
    parameter  int FIFO_DEPTH  = 2,
    localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr_r,
    input  logic [31:0]       ram_dout0,
    input  logic [31:0]       ram_dout1,
    input  logic [31:0]       ram_dout2,
    input  logic [31:0]       ram_dout3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data0,
    output logic [31:0]       out_data1,
    output logic [31:0]       out_data2,
    output logic [31:0]       out_data3,
    output logic              out_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] c_ADDR_MAX   = ADDR_W'(DEPTH_WORDS - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  c_PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]    c_FILL_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W+1:0]  c_FIFO_DEPTH = (PTR_W + 2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W:0]    r_num;
    logic [ADDR_W:0]    r_issued;
    logic               r_inflight;
    logic               r_inflight_last;

    logic [127:0]       r_mem_data [FIFO_DEPTH];
    logic               r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;

    logic               w_fifo_empty;
    logic [127:0]       w_capture;
    logic [127:0]       w_out_data;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [PTR_W+1:0]   w_occupancy;
    logic               w_issue_last;
    logic               w_start_ok;

    assign w_fifo_empty = (r_count == '0);
    assign w_capture    = {ram_dout3, ram_dout2, ram_dout1, ram_dout0};

    // An empty FIFO lets the word returning from the RAM fall straight
    // through to the output, which is what gives the 2-cycle start latency.
    always_comb begin
        w_out_data = '0;
        out_last   = 1'b0;
        if (!w_fifo_empty) begin
            w_out_data = r_mem_data[r_rptr];
            out_last   = r_mem_last[r_rptr];
        end else if (r_inflight) begin
            w_out_data = w_capture;
            out_last   = r_inflight_last;
        end
    end

    assign out_valid = !w_fifo_empty || r_inflight;
    assign out_data0 = w_out_data[31:0];
    assign out_data1 = w_out_data[63:32];
    assign out_data2 = w_out_data[95:64];
    assign out_data3 = w_out_data[127:96];

    assign w_accept = out_valid && out_ready;
    assign w_pop    = w_accept && !w_fifo_empty;
    // A returning word is stored unless it was consumed directly on bypass.
    assign w_push   = r_inflight && !(w_fifo_empty && out_ready);

    assign w_occupancy  = {1'b0, r_count} + {{(PTR_W + 1){1'b0}}, r_inflight};
    assign w_issue_last = (r_issued == (r_num - c_CNT_ONE));
    assign ram_re       = (r_state == ST_STREAM) && (r_issued < r_num) &&
                          (w_occupancy < c_FIFO_DEPTH);
    assign w_start_ok   = start && !busy;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                done = (r_state == ST_DONE);
                if (start) begin
                    w_state_nxt = (num_words == '0) ? ST_DONE : ST_STREAM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (ram_re && w_issue_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_accept && out_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_num           <= '0;
            r_issued        <= '0;
            ram_addr_r      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start_ok) begin
                r_num      <= num_words;
                r_issued   <= '0;
                ram_addr_r <= base_addr;
            end else if (ram_re) begin
                r_issued   <= r_issued + c_CNT_ONE;
                ram_addr_r <= (ram_addr_r == c_ADDR_MAX) ? '0 : ram_addr_r + c_ADDR_ONE;
            end

            r_inflight      <= ram_re;
            r_inflight_last <= ram_re && w_issue_last;

            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_FILL_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_FILL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_data[r_wptr] <= w_capture;
            r_mem_last[r_wptr] <= r_inflight_last;
        end
    end

endmodule
`default_nettype wire
